// File: rtl/swd_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// swd_xfer_ctrl
//
// Sits between the DAP command layer and the SWD bit engine (swdIF). It takes
// one transaction request at a time, drives the engine's go/idle handshake,
// re-issues the transaction on WAIT acks up to a caller-supplied limit, bounds
// every engine wait with a timeout, and returns one classified response.
//
// Ports
//   clk, rst          system clock; synchronous active-low reset
//   req_*             request channel (valid/ready): A[3:2], RnW, APnDP, wdata,
//                     plus wait_retries = max re-issues after a WAIT ack
//   rsp_*             response channel (valid/ready): status, raw ack, read
//                     data, number of engine transactions issued (sat. 255)
//   if_*              engine interface: request fields and go out; idle, ack,
//                     read data and parity error in
//   busy              high whenever the controller is not in IDLE
//
// Status codes: 0 OK, 1 WAIT exhausted, 2 FAULT, 3 protocol/no-ack,
//               4 read parity error, 5 timeout
// -----------------------------------------------------------------------------
module swd_xfer_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_addr32,
    input  logic        req_rnw,
    input  logic        req_apndp,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  wait_retries,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_status,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  rsp_tries,
    output logic [1:0]  if_addr32,
    output logic        if_rnw,
    output logic        if_apndp,
    output logic [31:0] if_dwrite,
    output logic        if_go,
    input  logic        if_idle,
    input  logic [2:0]  if_ack,
    input  logic [31:0] if_dread,
    input  logic        if_perr,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BUSY, S_CHECK, S_RESP, S_DRAIN
    } state_t;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_FAULT   = 3'd2;
    localparam logic [2:0] ST_PROTO   = 3'd3;
    localparam logic [2:0] ST_PARITY  = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_tmo_cnt;
    logic [7:0]  r_retry_cnt;
    logic        r_drain;       // response came from a BUSY timeout: drain engine after
    logic [2:0]  r_status;
    logic [2:0]  r_ack;
    logic [31:0] r_rdata;
    logic [7:0]  r_tries;
    logic [1:0]  r_addr32;
    logic        r_rnw;
    logic        r_apndp;
    logic [31:0] r_dwrite;

    logic        w_accept;
    logic        w_retry;
    logic        w_timeout;
    logic        w_tmo_hit;
    logic        w_enter_wait;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    // Timeout counter restarts whenever START or BUSY is (re)entered, including
    // the CHECK -> START hop of a WAIT retry.
    assign w_enter_wait = (w_state_nxt != r_state) &&
                          ((w_state_nxt == S_START) || (w_state_nxt == S_BUSY));

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_retry     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && if_idle) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            // go is held until the engine leaves idle: it only samples go on an
            // SWCLK rising strobe, which may be many clk cycles away.
            S_START: begin
                if (!if_idle) begin
                    w_state_nxt = S_BUSY;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_BUSY: begin
                if (if_idle) begin
                    w_state_nxt = S_CHECK;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_CHECK: begin
                if ((if_ack == ACK_WAIT) && (r_retry_cnt != 8'd0)) begin
                    w_retry     = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) w_state_nxt = r_drain ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (if_idle) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt   <= '0;
            r_retry_cnt <= '0;
            r_drain     <= 1'b0;
            r_status    <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_tries     <= '0;
            r_addr32    <= '0;
            r_rnw       <= 1'b0;
            r_apndp     <= 1'b0;
            r_dwrite    <= '0;
        end else begin
            if (w_enter_wait) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_START) || (r_state == S_BUSY)) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end

            if (w_accept) begin
                r_addr32    <= req_addr32;
                r_rnw       <= req_rnw;
                r_apndp     <= req_apndp;
                r_dwrite    <= req_wdata;
                r_retry_cnt <= wait_retries;
                r_tries     <= 8'd1;
                r_status    <= ST_OK;
                r_ack       <= '0;
                r_rdata     <= '0;
                r_drain     <= 1'b0;
            end

            if (r_state == S_CHECK) begin
                r_ack <= if_ack;
                if (w_retry) begin
                    r_retry_cnt <= r_retry_cnt - 8'd1;
                    if (r_tries != 8'hFF) r_tries <= r_tries + 8'd1;
                end else begin
                    case (if_ack)
                        ACK_OK: begin
                            if (r_rnw && if_perr) begin
                                r_status <= ST_PARITY;
                            end else begin
                                r_status <= ST_OK;
                                r_rdata  <= r_rnw ? if_dread : 32'd0;
                            end
                        end
                        ACK_WAIT:  r_status <= ST_WAIT;
                        ACK_FAULT: r_status <= ST_FAULT;
                        default:   r_status <= ST_PROTO;
                    endcase
                end
            end

            // An engine stuck mid-frame must finish before the next request.
            if (w_timeout) begin
                r_status <= ST_TIMEOUT;
                r_drain  <= (r_state == S_BUSY);
            end
        end
    end

    // ---------------- Outputs ----------------
    assign req_ready  = (r_state == S_IDLE) && if_idle;
    assign rsp_valid  = (r_state == S_RESP);
    assign if_go      = (r_state == S_START);
    assign busy       = (r_state != S_IDLE);
    assign rsp_status = r_status;
    assign rsp_ack    = r_ack;
    assign rsp_rdata  = r_rdata;
    assign rsp_tries  = r_tries;
    assign if_addr32  = r_addr32;
    assign if_rnw     = r_rnw;
    assign if_apndp   = r_apndp;
    assign if_dwrite  = r_dwrite;

endmodule

// File: tb/tb_swd_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_swd_xfer_ctrl
//
// Directed bench for swd_xfer_ctrl (TIMEOUT_CYCLES = 16). A small behavioural
// engine answers if_go: one clk after it sees go with idle high it drops idle,
// holds it low for ENG_FRAME clk edges, then raises idle together with an ack
// taken from a per-request sequence (falling back to a default ack).
// Modes let the engine ignore go entirely or hang mid-frame.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_swd_xfer_ctrl;

    localparam int TMO       = 16;
    localparam int ENG_FRAME = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_addr32;
    logic        req_rnw;
    logic        req_apndp;
    logic [31:0] req_wdata;
    logic [7:0]  wait_retries;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_tries;
    logic [1:0]  if_addr32;
    logic        if_rnw;
    logic        if_apndp;
    logic [31:0] if_dwrite;
    logic        if_go;
    logic        if_idle;
    logic [2:0]  if_ack;
    logic [31:0] if_dread;
    logic        if_perr;
    logic        busy;

    always #5 clk = ~clk;

    swd_xfer_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr32(req_addr32),
        .req_rnw(req_rnw), .req_apndp(req_apndp), .req_wdata(req_wdata),
        .wait_retries(wait_retries),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_tries(rsp_tries),
        .if_addr32(if_addr32), .if_rnw(if_rnw), .if_apndp(if_apndp),
        .if_dwrite(if_dwrite), .if_go(if_go), .if_idle(if_idle),
        .if_ack(if_ack), .if_dread(if_dread), .if_perr(if_perr),
        .busy(busy)
    );

    // ---------------- Engine model ----------------
    typedef enum int {M_NORMAL, M_STUCK1, M_HANG} eng_mode_t;

    eng_mode_t   eng_mode     = M_NORMAL;
    int          eng_frames   = 0;
    int          eng_base     = 0;
    logic [2:0]  eng_seq [4];
    logic [2:0]  eng_ack_dflt = 3'b001;
    logic [31:0] eng_dread    = '0;
    logic        eng_perr     = 1'b0;

    initial begin
        if_idle  = 1'b1;
        if_ack   = 3'b000;
        if_dread = '0;
        if_perr  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_mode != M_STUCK1 && if_go && if_idle) begin
                automatic int k = eng_frames - eng_base;
                eng_frames = eng_frames + 1;
                if_idle = 1'b0;
                repeat (ENG_FRAME) @(posedge clk);
                while (eng_mode == M_HANG) @(posedge clk);
                #1;
                if_ack   = (k < 4) ? eng_seq[k] : eng_ack_dflt;
                if_dread = eng_dread;
                if_perr  = eng_perr;
                if_idle  = 1'b1;
            end
        end
    end

    // ---------------- Monitor: go pulses and write-data stability ----------------
    int          go_rises = 0;
    logic        go_q     = 1'b0;
    int          dw_bad   = 0;
    logic [31:0] dw_exp   = '0;

    always @(posedge clk) begin
        if (if_go && !go_q) go_rises <= go_rises + 1;
        go_q <= if_go;
        if (busy && (if_dwrite !== dw_exp)) dw_bad <= dw_bad + 1;
    end

    // ---------------- Checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_eng(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                           input logic [2:0] dflt, input logic [31:0] dread, input logic perr);
        eng_seq[0]   = a0;
        eng_seq[1]   = a1;
        eng_seq[2]   = a2;
        eng_seq[3]   = dflt;
        eng_ack_dflt = dflt;
        eng_dread    = dread;
        eng_perr     = perr;
    endtask

    // Called on a falling edge with the controller idle; returns on the falling
    // edge right after the accepting rising edge.
    task automatic issue(input logic [1:0] a, input logic rnw, input logic apndp,
                         input logic [31:0] wd, input logic [7:0] retries);
        req_addr32   = a;
        req_rnw      = rnw;
        req_apndp    = apndp;
        req_wdata    = wd;
        wait_retries = retries;
        dw_exp       = wd;
        eng_base     = eng_frames;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid    = 1'b0;
        check("accepted", {31'd0, busy}, 32'd1);
    endtask

    // Counts falling edges (starting at the one after accept) until rsp_valid.
    task automatic wait_rsp(input int budget, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < budget) begin
            cycles++;
            @(negedge clk);
        end
        check("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic take_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drops", {31'd0, rsp_valid}, 32'd0);
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int lat;
        int go0;
        logic stable;

        rst          = 1'b0;
        req_valid    = 1'b0;
        req_addr32   = '0;
        req_rnw      = 1'b0;
        req_apndp    = 1'b0;
        req_wdata    = '0;
        wait_retries = '0;
        rsp_ready    = 1'b0;
        set_eng(3'b001, 3'b001, 3'b001, 3'b001, 32'd0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_if_go",     {31'd0, if_go}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_status",    {29'd0, rsp_status}, 32'd0);
        check("rst_tries",     {24'd0, rsp_tries}, 32'd0);
        check("rst_rdata",     rsp_rdata, 32'd0);
        check("rst_dwrite",    if_dwrite, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1) DP read, OK ack
        set_eng(3'b001, 3'b001, 3'b001, 3'b001, 32'h2BA0_1477, 1'b0);
        go0 = go_rises;
        issue(2'd0, 1'b1, 1'b0, 32'h0, 8'd0);
        wait_rsp(200, lat);
        check("rd_latency", lat, 6);
        check("rd_status",  {29'd0, rsp_status}, 32'd0);
        check("rd_rdata",   rsp_rdata, 32'h2BA0_1477);
        check("rd_tries",   {24'd0, rsp_tries}, 32'd1);
        check("rd_ack",     {29'd0, rsp_ack}, 32'd1);
        check("rd_if_rnw",  {31'd0, if_rnw}, 32'd1);
        check("rd_go",      go_rises - go0, 1);
        take_rsp();
        check("rd_ready_again", {31'd0, req_ready}, 32'd1);

        // 2) AP write, WAIT, WAIT, OK with 3 retries allowed
        set_eng(3'b010, 3'b010, 3'b001, 3'b001, 32'h1111_2222, 1'b0);
        go0 = dw_bad;
        lat = go_rises;
        issue(2'd1, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'd3);
        check("wr_if_apndp", {31'd0, if_apndp}, 32'd1);
        check("wr_if_addr",  {30'd0, if_addr32}, 32'd1);
        begin
            int c;
            wait_rsp(400, c);
        end
        check("wr_go_pulses", go_rises - lat, 3);
        check("wr_dwrite_stable", dw_bad - go0, 0);
        check("wr_dwrite",   if_dwrite, 32'hDEAD_BEEF);
        check("wr_status",   {29'd0, rsp_status}, 32'd0);
        check("wr_tries",    {24'd0, rsp_tries}, 32'd3);
        check("wr_rdata",    rsp_rdata, 32'd0);
        take_rsp();

        // 3) WAIT exhausted with 2 retries, then with none
        set_eng(3'b010, 3'b010, 3'b010, 3'b010, 32'h0, 1'b0);
        go0 = go_rises;
        issue(2'd2, 1'b1, 1'b0, 32'h0, 8'd2);
        wait_rsp(400, lat);
        check("wx2_go_pulses", go_rises - go0, 3);
        check("wx2_status", {29'd0, rsp_status}, 32'd1);
        check("wx2_ack",    {29'd0, rsp_ack}, 32'd2);
        check("wx2_tries",  {24'd0, rsp_tries}, 32'd3);
        take_rsp();
        issue(2'd2, 1'b1, 1'b0, 32'h0, 8'd0);
        wait_rsp(200, lat);
        check("wx0_status", {29'd0, rsp_status}, 32'd1);
        check("wx0_tries",  {24'd0, rsp_tries}, 32'd1);
        take_rsp();

        // 4) FAULT, protocol error, read parity error, write ignores parity
        set_eng(3'b100, 3'b100, 3'b100, 3'b100, 32'h5555_AAAA, 1'b0);
        issue(2'd3, 1'b1, 1'b1, 32'h0, 8'd4);
        wait_rsp(200, lat);
        check("fault_status", {29'd0, rsp_status}, 32'd2);
        check("fault_ack",    {29'd0, rsp_ack}, 32'd4);
        check("fault_rdata",  rsp_rdata, 32'd0);
        take_rsp();
        set_eng(3'b111, 3'b111, 3'b111, 3'b111, 32'h5555_AAAA, 1'b0);
        issue(2'd0, 1'b0, 1'b0, 32'h0000_00F0, 8'd4);
        wait_rsp(200, lat);
        check("proto_status", {29'd0, rsp_status}, 32'd3);
        check("proto_ack",    {29'd0, rsp_ack}, 32'd7);
        take_rsp();
        set_eng(3'b001, 3'b001, 3'b001, 3'b001, 32'h1234_5678, 1'b1);
        issue(2'd1, 1'b1, 1'b1, 32'h0, 8'd0);
        wait_rsp(200, lat);
        check("perr_status", {29'd0, rsp_status}, 32'd4);
        check("perr_rdata",  rsp_rdata, 32'd0);
        take_rsp();
        // Write with perr set: parity only applies to read data; rsp_ready held
        // high beforehand gives a single-cycle response.
        rsp_ready = 1'b1;
        issue(2'd1, 1'b0, 1'b1, 32'hCAFE_F00D, 8'd0);
        wait_rsp(200, lat);
        check("wperr_status", {29'd0, rsp_status}, 32'd0);
        @(negedge clk);
        check("one_cycle_rsp", {31'd0, rsp_valid}, 32'd0);
        check("one_cycle_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;

        // 5) Tries saturate at 255 (255 retries -> 256 engine transactions)
        set_eng(3'b010, 3'b010, 3'b010, 3'b010, 32'h0, 1'b0);
        go0 = go_rises;
        issue(2'd0, 1'b1, 1'b0, 32'h0, 8'd255);
        wait_rsp(4000, lat);
        check("sat_go_pulses", go_rises - go0, 256);
        check("sat_tries",  {24'd0, rsp_tries}, 32'd255);
        check("sat_status", {29'd0, rsp_status}, 32'd1);
        take_rsp();

        // 6) Timeout in START: engine never leaves idle
        eng_mode = M_STUCK1;
        go0 = go_rises;
        issue(2'd0, 1'b1, 1'b0, 32'h0, 8'd0);
        wait_rsp(100, lat);
        check("tmo_start_cycles", lat, 16);
        check("tmo_start_status", {29'd0, rsp_status}, 32'd5);
        check("tmo_start_go",     {31'd0, if_go}, 32'd0);
        check("tmo_start_pulses", go_rises - go0, 1);
        take_rsp();
        check("tmo_start_no_drain", {31'd0, req_ready}, 32'd1);
        eng_mode = M_NORMAL;

        // 7) Timeout in BUSY: engine hangs mid-frame, then DRAIN
        set_eng(3'b001, 3'b001, 3'b001, 3'b001, 32'h0, 1'b0);
        eng_mode = M_HANG;
        issue(2'd0, 1'b1, 1'b0, 32'h0, 8'd0);
        wait_rsp(100, lat);
        check("tmo_busy_cycles", lat, 17);
        check("tmo_busy_status", {29'd0, rsp_status}, 32'd5);
        check("tmo_busy_go",     {31'd0, if_go}, 32'd0);
        take_rsp();
        repeat (5) @(negedge clk);
        check("drain_ready", {31'd0, req_ready}, 32'd0);
        check("drain_busy",  {31'd0, busy}, 32'd1);
        eng_mode = M_NORMAL;
        @(negedge clk);
        check("drain_edge_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("drain_exit_ready", {31'd0, req_ready}, 32'd1);

        // 8) Response backpressure
        set_eng(3'b001, 3'b001, 3'b001, 3'b001, 32'hA5A5_0F0F, 1'b0);
        issue(2'd3, 1'b1, 1'b0, 32'h0, 8'd0);
        wait_rsp(200, lat);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_status === 3'd0 && rsp_rdata === 32'hA5A5_0F0F &&
                  rsp_tries === 8'd1 && rsp_ack === 3'b001 && req_ready === 1'b0))
                stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        check("bp_rdata",  rsp_rdata, 32'hA5A5_0F0F);
        take_rsp();
        check("bp_ready_after", {31'd0, req_ready}, 32'd1);

        // 9) Reset while BUSY aborts the transfer
        eng_mode = M_HANG;
        issue(2'd2, 1'b1, 1'b1, 32'h0, 8'd0);
        @(negedge clk);
        check("pre_rst_in_busy", {30'd0, busy, if_go}, 32'd2);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_go",        {31'd0, if_go}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy}, 32'd0);
        check("mid_rst_if_rnw",    {31'd0, if_rnw}, 32'd0);
        check("mid_rst_ready_eng_busy", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        eng_mode = M_NORMAL;
        repeat (2) @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        set_eng(3'b001, 3'b001, 3'b001, 3'b001, 32'h0BAD_C0DE, 1'b0);
        issue(2'd1, 1'b1, 1'b0, 32'h0, 8'd0);
        wait_rsp(200, lat);
        check("post_rst_rdata",  rsp_rdata, 32'h0BAD_C0DE);
        check("post_rst_status", {29'd0, rsp_status}, 32'd0);
        take_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
